comm_master: RTL and testbench

- Host-side initiator for the analyzer command channel; the opposite end of the command/response protocol.
- Accepts a 16-bit command and serializes it as two bytes (high byte first) onto a UART transmitter byte interface.
- Collects the response byte(s) from a UART receiver byte interface.
- Flags ACK/NAK, completion and timeout.
- Used in the bench host model and in the loopback self-test build.

---
 rtl/comm_pkg.sv | 33 +++
 rtl/resp_tmo.sv | 34 +++
 rtl/comm_master.sv | 136 +++++++++++++
 tb/tb_comm_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the analyzer command channel initiator.
package comm_pkg;

  typedef enum logic [1:0] {
    RD  = 2'b00,
    WR  = 2'b01,
    DMP = 2'b10,
    BAD = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO,
    RX_WAIT
  } state_t;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  // Judge a single-byte response. An illegal dump or opcode 11 should draw an
  // explicit NAK byte, and any other byte is a protocol error, so both flag it.
  function automatic logic resp_is_nak(opcode_t op, logic [7:0] b);
    logic flag;
    case (op)
      RD:      flag = 1'b0;
      WR:      flag = (b != ACK);
      default: flag = 1'b1;
    endcase
    return flag;
  endfunction

endpackage

// File: rtl/resp_tmo.sv
// Clearable response timeout counter; holds at its terminal count until cleared.
module resp_tmo #(
  parameter int TMO_CYCLES = 1000000,
  parameter int TMO_W      = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/comm_master.sv
// Host-side command initiator: sends a 16-bit command as two UART bytes and
// collects the response, flagging completion, NAK and timeout.
module comm_master
  import comm_pkg::*;
#(
  parameter int DUMP_BYTES = 384,
  parameter int CNT_W      = 9,
  parameter int TMO_CYCLES = 1000000,
  parameter int TMO_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cmd,
  input  logic             snd_cmd,
  output logic [7:0]       tx_data,
  output logic             trmt,
  input  logic             tx_done,
  input  logic [7:0]       rx_data,
  input  logic             rx_rdy,
  output logic             clr_rx_rdy,
  output logic [7:0]       resp,
  output logic             resp_vld,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             busy,
  output logic             cmd_cmplt,
  output logic             nak,
  output logic             timeout
);

  localparam logic [CNT_W:0] DUMP_LEN = (CNT_W + 1)'(DUMP_BYTES);

  state_t           state_q;
  opcode_t          op_q;
  logic             dump_q;
  logic [7:0]       lo_q, tx_data_q, resp_q;
  logic             trmt_q, resp_vld_q, cmd_cmplt_q, nak_q, timeout_q;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             cmd_is_dump, rx_take, last_byte, tmo_expired;

  assign cmd_is_dump = (cmd[15:14] == DMP) && (cmd[10:8] >= 3'd1) && (cmd[10:8] <= 3'd5);
  assign rx_take     = (state_q == RX_WAIT) && rx_rdy;
  assign cnt_inc     = {1'b0, byte_cnt_q} + 1'b1;
  assign byte_cnt_d  = (cnt_inc > DUMP_LEN) ? byte_cnt_q : cnt_inc[CNT_W-1:0];
  // Non-dump commands expect one byte and byte_cnt starts at zero, so the
  // first consumed byte is always the last.
  assign last_byte   = dump_q ? (cnt_inc == DUMP_LEN) : 1'b1;

  resp_tmo #(
    .TMO_CYCLES(TMO_CYCLES),
    .TMO_W     (TMO_W)
  ) u_tmo (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    ((state_q != RX_WAIT) || rx_rdy),
    .en_i     ((state_q == RX_WAIT) && !rx_rdy),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= RD;
      dump_q      <= 1'b0;
      lo_q        <= '0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_q      <= '0;
      resp_vld_q  <= 1'b0;
      byte_cnt_q  <= '0;
      cmd_cmplt_q <= 1'b0;
      nak_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      trmt_q     <= 1'b0;
      resp_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (snd_cmd) begin
            op_q        <= opcode_t'(cmd[15:14]);
            dump_q      <= cmd_is_dump;
            lo_q        <= cmd[7:0];
            tx_data_q   <= cmd[15:8];
            trmt_q      <= 1'b1;
            cmd_cmplt_q <= 1'b0;
            nak_q       <= 1'b0;
            timeout_q   <= 1'b0;
            byte_cnt_q  <= '0;
            state_q     <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (tx_done) begin
            tx_data_q <= lo_q;
            trmt_q    <= 1'b1;
            state_q   <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_done)
            state_q <= RX_WAIT;
        end
        RX_WAIT: begin
          // A byte arriving on the terminal-count cycle beats the timeout.
          if (rx_rdy) begin
            resp_q     <= rx_data;
            resp_vld_q <= 1'b1;
            byte_cnt_q <= byte_cnt_d;
            if (last_byte) begin
              cmd_cmplt_q <= 1'b1;
              nak_q       <= !dump_q && resp_is_nak(op_q, rx_data);
              state_q     <= IDLE;
            end
          end else if (tmo_expired) begin
            timeout_q   <= 1'b1;
            cmd_cmplt_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign trmt       = trmt_q;
  assign clr_rx_rdy = rx_take;
  assign resp       = resp_q;
  assign resp_vld   = resp_vld_q;
  assign byte_cnt   = byte_cnt_q;
  assign busy       = (state_q != IDLE);
  assign cmd_cmplt  = cmd_cmplt_q;
  assign nak        = nak_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_comm_master.sv
// Directed bench for comm_master: write/read/dump/illegal-dump transactions,
// receive timeout and mid-command reset.
module tb_comm_master;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [7:0]  resp;
  logic        resp_vld;
  logic [8:0]  byte_cnt;
  logic        busy;
  logic        cmd_cmplt;
  logic        nak;
  logic        timeout;

  int checkCount = 0;
  int errorCount = 0;
  int vldCount   = 0;
  int clrCount   = 0;

  always #5 clk = ~clk;

  comm_master #(
    .DUMP_BYTES(384),
    .CNT_W     (9),
    .TMO_CYCLES(TMO),
    .TMO_W     (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .snd_cmd   (snd_cmd),
    .tx_data   (tx_data),
    .trmt      (trmt),
    .tx_done   (tx_done),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .clr_rx_rdy(clr_rx_rdy),
    .resp      (resp),
    .resp_vld  (resp_vld),
    .byte_cnt  (byte_cnt),
    .busy      (busy),
    .cmd_cmplt (cmd_cmplt),
    .nak       (nak),
    .timeout   (timeout)
  );

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (resp_vld)   vldCount <= vldCount + 1;
    if (clr_rx_rdy) clrCount <= clrCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txDone();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Issue a command and walk both transmit bytes; optionally finish the low
  // byte so the DUT lands in the receive phase.
  task automatic applyStimulus(input logic [15:0] c, input logic goToRx);
    cmd     = c;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    checkOutput("trmt_hi", trmt, 1);
    checkOutput("tx_hi", tx_data, c[15:8]);
    checkOutput("busy_send", busy, 1);
    checkOutput("cmplt_cleared", cmd_cmplt, 0);
    checkOutput("nak_cleared", nak, 0);
    checkOutput("tmo_cleared", timeout, 0);
    checkOutput("cnt_cleared", byte_cnt, 0);
    tick();
    checkOutput("trmt_hi_one_cycle", trmt, 0);
    txDone();
    checkOutput("trmt_lo", trmt, 1);
    checkOutput("tx_lo", tx_data, c[7:0]);
    tick();
    checkOutput("trmt_lo_one_cycle", trmt, 0);
    if (goToRx) begin
      txDone();
      checkOutput("trmt_quiet_rx", trmt, 0);
    end
  endtask

  task automatic sendResponse(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    checkOutput("clr_rx_rdy", clr_rx_rdy, 1);
    tick();
    rx_rdy = 1'b0;
    checkOutput("resp_vld", resp_vld, 1);
    checkOutput("resp", resp, b);
  endtask

  initial begin
    int vldBase;
    int clrBase;

    rst     = 1'b1;
    cmd     = '0;
    snd_cmd = 1'b0;
    tx_done = 1'b0;
    rx_data = '0;
    rx_rdy  = 1'b0;
    tick();
    tick();
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_trmt", trmt, 0);
    checkOutput("rst_resp", resp, 0);
    checkOutput("rst_resp_vld", resp_vld, 0);
    checkOutput("rst_byte_cnt", byte_cnt, 0);
    checkOutput("rst_cmplt", cmd_cmplt, 0);
    checkOutput("rst_nak", nak, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_clr_rx", clr_rx_rdy, 0);
    rst = 1'b0;
    tick();

    $display("[TB] write with ACK");
    applyStimulus(16'h4713, 1'b1);
    sendResponse(8'hA5);
    checkOutput("wr_cmplt", cmd_cmplt, 1);
    checkOutput("wr_nak", nak, 0);
    checkOutput("wr_cnt", byte_cnt, 1);
    checkOutput("wr_busy", busy, 0);
    tick();
    checkOutput("wr_vld_one_cycle", resp_vld, 0);

    $display("[TB] write with NAK, snd_cmd ignored while busy");
    applyStimulus(16'h4013, 1'b1);
    cmd     = 16'h8100;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    checkOutput("busy_ignore_snd", busy, 1);
    checkOutput("trmt_ignore_snd", trmt, 0);
    checkOutput("tx_hold_ignore_snd", tx_data, 8'h13);
    sendResponse(8'hEE);
    checkOutput("wrnak_nak", nak, 1);
    checkOutput("wrnak_cmplt", cmd_cmplt, 1);

    $display("[TB] read");
    applyStimulus(16'h0700, 1'b1);
    checkOutput("rd_busy_wait", busy, 1);
    sendResponse(8'hAA);
    checkOutput("rd_busy_drop", busy, 0);
    checkOutput("rd_nak", nak, 0);
    checkOutput("rd_cmplt", cmd_cmplt, 1);
    checkOutput("rd_cnt", byte_cnt, 1);

    $display("[TB] dump of 384 bytes");
    applyStimulus(16'h8100, 1'b1);
    vldBase = vldCount;
    clrBase = clrCount;
    for (int i = 0; i < 384; i++) begin
      sendResponse(8'(i % 128));
      if (i == 382) begin
        checkOutput("dmp_not_done", cmd_cmplt, 0);
        checkOutput("dmp_busy_mid", busy, 1);
        checkOutput("dmp_cnt_mid", byte_cnt, 383);
      end
    end
    checkOutput("dmp_cmplt", cmd_cmplt, 1);
    checkOutput("dmp_cnt", byte_cnt, 384);
    checkOutput("dmp_nak", nak, 0);
    checkOutput("dmp_busy", busy, 0);
    tick();
    checkOutput("dmp_vld_pulses", vldCount - vldBase, 384);
    checkOutput("dmp_clr_pulses", clrCount - clrBase, 384);

    $display("[TB] illegal dump channel");
    applyStimulus(16'h8600, 1'b1);
    sendResponse(8'hEE);
    checkOutput("ild_nak", nak, 1);
    checkOutput("ild_cmplt", cmd_cmplt, 1);
    checkOutput("ild_cnt", byte_cnt, 1);
    checkOutput("ild_busy", busy, 0);

    $display("[TB] read timeout");
    applyStimulus(16'h0700, 1'b1);
    for (int k = 1; k < TMO; k++) begin
      tx_done = (k == 10);
      tick();
      tx_done = 1'b0;
      if (k == 10) checkOutput("trmt_ignore_txdone_rx", trmt, 0);
    end
    checkOutput("tmo_early", timeout, 0);
    checkOutput("tmo_cmplt_early", cmd_cmplt, 0);
    checkOutput("tmo_busy_early", busy, 1);
    tick();
    checkOutput("tmo_set", timeout, 1);
    checkOutput("tmo_cmplt", cmd_cmplt, 1);
    checkOutput("tmo_busy", busy, 0);
    checkOutput("tmo_cnt", byte_cnt, 0);
    checkOutput("tmo_nak", nak, 0);

    $display("[TB] reset during SEND_LO");
    applyStimulus(16'h0700, 1'b0);
    checkOutput("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_tx_data", tx_data, 0);
    checkOutput("mid_rst_trmt", trmt, 0);
    checkOutput("mid_rst_resp", resp, 0);
    checkOutput("mid_rst_cnt", byte_cnt, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_cmplt", cmd_cmplt, 0);
    checkOutput("mid_rst_nak", nak, 0);
    checkOutput("mid_rst_timeout", timeout, 0);
    tx_done = 1'b1;
    rx_data = 8'h55;
    rx_rdy  = 1'b1;
    #1;
    checkOutput("idle_no_clr_rx", clr_rx_rdy, 0);
    tick();
    tx_done = 1'b0;
    rx_rdy  = 1'b0;
    checkOutput("idle_no_trmt", trmt, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_no_vld", resp_vld, 0);
    checkOutput("idle_resp_hold", resp, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
